// File: rtl/cmp_stream_tracker.sv
// cmp_stream_tracker: per-beat a/b compare in unsigned, two's complement or
// sign-magnitude format, plus running max/min (with beat index) of a across
// a framed stream. Every output is registered.
module cmp_stream_tracker #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [2:0]       flag,
  output logic             frame_done,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] min_idx,
  output logic             idx_ovf
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       fmode;
  logic [IDX_W-1:0] idx, idx_inc;
  logic             idx_sat, start, beat, closing;
  logic [2:0]       c_pair, c_max, c_min;

  // Three-way compare, returns {lt, gt, eq}. Mode 11 falls into the unsigned
  // default. Sign-magnitude treats +0 and -0 as equal.
  function automatic logic [2:0] cmp3(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y,
                                      input logic [1:0]       m);
    logic gt, lt;
    logic xz, yz;
    gt = 1'b0;
    lt = 1'b0;
    xz = ~|x[WIDTH-2:0];
    yz = ~|y[WIDTH-2:0];
    case (m)
      2'b01: begin
        gt = $signed(x) > $signed(y);
        lt = $signed(x) < $signed(y);
      end
      2'b10: begin
        if (xz && yz) begin
          gt = 1'b0;
          lt = 1'b0;
        end else if (x[WIDTH-1] != y[WIDTH-1]) begin
          gt = ~x[WIDTH-1];
          lt = x[WIDTH-1];
        end else if (!x[WIDTH-1]) begin
          gt = x[WIDTH-2:0] > y[WIDTH-2:0];
          lt = x[WIDTH-2:0] < y[WIDTH-2:0];
        end else begin
          // both negative: larger magnitude is the smaller value
          gt = x[WIDTH-2:0] < y[WIDTH-2:0];
          lt = x[WIDTH-2:0] > y[WIDTH-2:0];
        end
      end
      default: begin
        gt = x > y;
        lt = x < y;
      end
    endcase
    return {lt, gt, ~(lt | gt)};
  endfunction

  // Beat classification and compares against the running extremes.
  always_comb begin
    start   = in_valid & in_first;
    beat    = in_valid & ~in_first & (state == ACTIVE);
    closing = in_valid & in_last & (in_first | (state == ACTIVE));
    idx_sat = &idx;
    idx_inc = idx_sat ? idx : idx + 1'b1;
    c_pair  = cmp3(a, b, mode);
    c_max   = cmp3(a, max_val, fmode);
    c_min   = cmp3(a, min_val, fmode);
  end

  // Tracker next state: first always (re)opens, last closes.
  always_comb begin
    state_nxt = state;
    if (start)
      state_nxt = in_last ? IDLE : ACTIVE;
    else if (beat && in_last)
      state_nxt = IDLE;
  end

  // Tracker state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pair path: one-cycle latency, flag holds while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      flag      <= 3'b000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) flag <= c_pair;
    end
  end

  // Frame statistics: load on first, strict updates keep earliest index,
  // results hold after the frame until the next first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      fmode      <= 2'b00;
      idx        <= '0;
      max_val    <= '0;
      min_val    <= '0;
      max_idx    <= '0;
      min_idx    <= '0;
      idx_ovf    <= 1'b0;
    end else begin
      frame_done <= closing;
      if (start) begin
        fmode   <= mode;
        idx     <= '0;
        max_val <= a;
        min_val <= a;
        max_idx <= '0;
        min_idx <= '0;
        idx_ovf <= 1'b0;
      end else if (beat) begin
        idx <= idx_inc;
        if (idx_sat) idx_ovf <= 1'b1;
        if (c_max[1]) begin
          max_val <= a;
          max_idx <= idx_inc;
        end
        if (c_min[2]) begin
          min_val <= a;
          min_idx <= idx_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Bench for cmp_stream_tracker: pair-path vector table, hand-written frame
// sequences, then random traffic against a value-level reference model.
// Two instances share inputs: IDX_W=8 and IDX_W=2 (saturation).
module tb_cmp_stream_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_first, in_last;
  logic [1:0] mode;
  logic [7:0] a, b;

  logic       ov0, fd0, ovf0, ov1, fd1, ovf1;
  logic [2:0] fl0, fl1;
  logic [7:0] mxv0, mnv0, mxi0, mni0, mxv1, mnv1;
  logic [1:0] mxi1, mni1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_stream_tracker #(.WIDTH(8), .IDX_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .mode(mode), .a(a), .b(b), .out_valid(ov0),
    .flag(fl0), .frame_done(fd0), .max_val(mxv0), .min_val(mnv0),
    .max_idx(mxi0), .min_idx(mni0), .idx_ovf(ovf0));

  cmp_stream_tracker #(.WIDTH(8), .IDX_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .mode(mode), .a(a), .b(b), .out_valid(ov1),
    .flag(fl1), .frame_done(fd1), .max_val(mxv1), .min_val(mnv1),
    .max_idx(mxi1), .min_idx(mni1), .idx_ovf(ovf1));

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] maxv, minv;
    int         maxi, mini;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [1:0] m;
    logic [7:0] av, bv;
    logic [2:0] f;
  } vec_t;

  logic [7:0] fq[$];
  logic [1:0] fm;
  logic       act, res_known, exp_ov, exp_done;
  logic [2:0] exp_flag;
  res_t       er[2];

  // numeric value of a sample under a format
  function automatic int sval(input logic [7:0] x, input logic [1:0] m);
    case (m)
      2'b01:   return int'($signed(x));
      2'b10:   return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
      default: return int'(x);
    endcase
  endfunction

  function automatic logic [2:0] mflag(input logic [7:0] x, input logic [7:0] y,
                                       input logic [1:0] m);
    int vx, vy;
    vx = sval(x, m);
    vy = sval(y, m);
    if (vx == vy) return 3'b001;
    if (vx > vy)  return 3'b010;
    return 3'b100;
  endfunction

  task automatic finish_frame();
    for (int k = 0; k < 2; k++) begin
      int lim, mx, mn;
      lim = (k == 0) ? 255 : 3;
      mx = 0;
      mn = 0;
      for (int i = 1; i < fq.size(); i++) begin
        if (sval(fq[i], fm) > sval(fq[mx], fm)) mx = i;
        if (sval(fq[i], fm) < sval(fq[mn], fm)) mn = i;
      end
      er[k].maxv = fq[mx];
      er[k].minv = fq[mn];
      er[k].maxi = (mx > lim) ? lim : mx;
      er[k].mini = (mn > lim) ? lim : mn;
      er[k].ovf  = fq.size() > lim + 1;
    end
  endtask

  task automatic model_reset();
    fq.delete();
    fm = 2'b00;
    act = 1'b0;
    res_known = 1'b0;
    exp_ov = 1'b0;
    exp_done = 1'b0;
    exp_flag = 3'b000;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  task automatic check_all();
    chk("out_valid", int'(ov0), int'(exp_ov));
    chk("flag", int'(fl0), int'(exp_flag));
    chk("flag_i2", int'(fl1), int'(exp_flag));
    chk("frame_done", int'(fd0), int'(exp_done));
    chk("frame_done_i2", int'(fd1), int'(exp_done));
    if (res_known) begin
      chk("max_val", int'(mxv0), int'(er[0].maxv));
      chk("min_val", int'(mnv0), int'(er[0].minv));
      chk("max_idx", int'(mxi0), er[0].maxi);
      chk("min_idx", int'(mni0), er[0].mini);
      chk("idx_ovf", int'(ovf0), int'(er[0].ovf));
      chk("max_val_i2", int'(mxv1), int'(er[1].maxv));
      chk("min_val_i2", int'(mnv1), int'(er[1].minv));
      chk("max_idx_i2", int'(mxi1), er[1].maxi);
      chk("min_idx_i2", int'(mni1), er[1].mini);
      chk("idx_ovf_i2", int'(ovf1), int'(er[1].ovf));
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ov"}, int'(ov0 | ov1), 0);
    chk({nm, "_flag"}, int'(fl0 | fl1), 0);
    chk({nm, "_done"}, int'(fd0 | fd1), 0);
    chk({nm, "_max"}, int'(mxv0 | mxv1), 0);
    chk({nm, "_min"}, int'(mnv0 | mnv1), 0);
    chk({nm, "_idx"}, int'(mxi0 | mni0 | 8'(mxi1) | 8'(mni1)), 0);
    chk({nm, "_ovf"}, int'(ovf0 | ovf1), 0);
  endtask

  // apply one beat at posedge+1, advance the model, check after next edge
  task automatic drive(input logic v, input logic f, input logic l,
                       input logic [1:0] m, input logic [7:0] av,
                       input logic [7:0] bv);
    in_valid = v; in_first = f; in_last = l; mode = m; a = av; b = bv;
    exp_ov = v;
    exp_done = 1'b0;
    if (v) exp_flag = mflag(av, bv, m);
    if (v && f) begin
      fq.delete();
      fq.push_back(av);
      fm = m;
      act = 1'b1;
      res_known = 1'b0;
    end else if (v && act) begin
      fq.push_back(av);
    end
    if (v && l && act) begin
      finish_frame();
      exp_done = 1'b1;
      act = 1'b0;
      res_known = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t tv[11];
    logic [7:0] fr[5];
    tv[0]  = '{2'b00, 8'h80, 8'h7F, 3'b010};
    tv[1]  = '{2'b01, 8'h80, 8'h7F, 3'b100};
    tv[2]  = '{2'b11, 8'h80, 8'h7F, 3'b010};
    tv[3]  = '{2'b10, 8'h80, 8'h00, 3'b001};
    tv[4]  = '{2'b10, 8'h85, 8'h83, 3'b100};
    tv[5]  = '{2'b10, 8'h03, 8'h81, 3'b010};
    tv[6]  = '{2'b01, 8'h7F, 8'h80, 3'b010};
    tv[7]  = '{2'b00, 8'h55, 8'h55, 3'b001};
    tv[8]  = '{2'b10, 8'h00, 8'h01, 3'b100};
    tv[9]  = '{2'b01, 8'hFF, 8'hFF, 3'b001};
    tv[10] = '{2'b10, 8'h81, 8'h02, 3'b100};

    rst = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    mode = 2'b00; a = 8'h00; b = 8'h00;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // pair-path table
    foreach (tv[i]) begin
      drive(1'b1, 1'b0, 1'b0, tv[i].m, tv[i].av, tv[i].bv);
      chk("tbl_flag", int'(fl0), int'(tv[i].f));
    end
    idle();
    chk("flag_hold", int'(fl0), int'(tv[10].f));

    // signed frame 03,FE,07,07,F8
    fr = '{8'h03, 8'hFE, 8'h07, 8'h07, 8'hF8};
    for (int i = 0; i < 5; i++)
      drive(1'b1, i == 0, i == 4, 2'b01, fr[i], 8'h00);
    chk("frm_done", int'(fd0), 1);
    chk("frm_max", int'(mxv0), 8'h07);
    chk("frm_maxi", int'(mxi0), 2);
    chk("frm_min", int'(mnv0), 8'hF8);
    chk("frm_mini", int'(mni0), 4);
    chk("frm_ovf", int'(ovf0), 0);
    idle();
    chk("frm_pulse", int'(fd0), 0);
    chk("frm_hold", int'(mxv0), 8'h07);
    idle();

    // single-beat frame
    drive(1'b1, 1'b1, 1'b1, 2'b00, 8'h42, 8'h42);
    chk("one_done", int'(fd0), 1);
    chk("one_max", int'(mxv0), 8'h42);
    chk("one_min", int'(mnv0), 8'h42);
    chk("one_idx", int'(mxi0 | mni0), 0);
    idle();

    // restart mid-frame
    drive(1'b1, 1'b1, 1'b0, 2'b00, 8'h10, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 8'h20, 8'h00);
    chk("rs_nodone", int'(fd0), 0);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 8'h05, 8'h00);
    chk("rs_nodone2", int'(fd0), 0);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 8'h01, 8'h00);
    chk("rs_done", int'(fd0), 1);
    chk("rs_max", int'(mxv0), 8'h05);
    chk("rs_maxi", int'(mxi0), 0);
    chk("rs_min", int'(mnv0), 8'h01);
    chk("rs_mini", int'(mni0), 1);
    idle();

    // six-beat frame: saturates the IDX_W=2 instance
    for (int i = 0; i < 6; i++)
      drive(1'b1, i == 0, i == 5, 2'b00, 8'(i + 1), 8'h00);
    chk("sat_ovf_i2", int'(ovf1), 1);
    chk("sat_maxi_i2", int'(mxi1), 3);
    chk("sat_maxi", int'(mxi0), 5);
    chk("sat_ovf", int'(ovf0), 0);
    idle();

    // reset asserted between edges mid-frame
    drive(1'b1, 1'b1, 1'b0, 2'b01, 8'h33, 8'h11);
    drive(1'b1, 1'b0, 1'b0, 2'b01, 8'h44, 8'h11);
    rst = 1'b1;
    #2;
    check_zero("midrst");
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // last with no frame open
    drive(1'b1, 1'b0, 1'b1, 2'b00, 8'h05, 8'h03);
    chk("orphan_done", int'(fd0), 0);
    chk("orphan_flag", int'(fl0), 3'b010);
    idle();
    chk("orphan_done2", int'(fd0), 0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic v, f, l;
      logic [1:0] m;
      logic [7:0] av, bv;
      v  = ($urandom_range(3) != 0);
      f  = ($urandom_range(7) == 0);
      l  = ($urandom_range(5) == 0);
      m  = 2'($urandom_range(3));
      av = 8'($urandom);
      bv = 8'($urandom);
      if ($urandom_range(5) == 0) bv = av;
      if ($urandom_range(9) == 0) bv = av ^ 8'h80;
      if ($urandom_range(15) == 0) av = 8'h80;
      drive(v, f, l, m, av, bv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_stream_tracker.md
Name: cmp_stream_tracker

Overview:
- Parametrised, pipelined successor to the team's 8-bit pairwise comparator.
- Each accepted beat compares a against b in a selectable number format: unsigned, two's complement or sign-magnitude.
- Across a framed stream of a values, the block also tracks the running maximum and minimum and the beat index of each.
- Sits between a sample source and downstream statistics logic; all outputs are registered.

Parameters:
- WIDTH, 8, operand width in bits; must be 2 or more.
- IDX_W, 8, width of beat-index counter and of max_idx/min_idx.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat qualifier; no back-pressure, so every valid beat is accepted.
- in_first  input  1  first beat of a frame; qualified by in_valid.
- in_last  input  1  last beat of a frame; qualified by in_valid.
- mode  input  2  format: 00 unsigned, 01 two's complement, 10 sign-magnitude (MSB is the sign), 11 reserved and treated as 00.
- a  input  WIDTH  operand A, which is also the tracked sample.
- b  input  WIDTH  operand B.
- out_valid  output  1  flag is valid.
- flag  output  3  pair result: [0] a==b, [1] a>b, [2] a<b; exactly one bit set when out_valid is high.
- frame_done  output  1  one-cycle pulse when frame results are valid.
- max_val  output  WIDTH  frame maximum of a.
- min_val  output  WIDTH  frame minimum of a.
- max_idx  output  IDX_W  beat index (0-based) of the maximum.
- min_idx  output  IDX_W  beat index of the minimum.
- idx_ovf  output  1  frame length exceeded 2^IDX_W beats.

Behaviour:
- Reset (async, immediate): all outputs are 0, including flag=3'b000. The frame-active flag, beat counter and latched frame mode are cleared.
- Pair path:
  - Latency is 1 cycle: out_valid(t+1)=in_valid(t).
  - flag(t+1) is the compare of a(t), b(t) under mode(t).
  - When in_valid is low, out_valid=0 and flag holds its last value.
- Sign-magnitude rules:
  - Compare by sign first, then by magnitude. For two negatives the larger magnitude is the smaller value.
  - +0 and -0 are equal (flag=001), and are equal to each other in min/max tracking.
- Tracker uses a frame-active flag, a beat counter, and a frame mode latched on the in_first beat.
- in_valid & in_first:
  - Start a new frame: idx=0, max_val=min_val=a, max_idx=min_idx=0, idx_ovf=0, frame_active=1.
  - Any frame in progress is abandoned with no frame_done.
- in_valid & frame_active & !in_first:
  - Increment idx.
  - If a > max_val under the frame mode, update max_val/max_idx.
  - If a < min_val, update min_val/min_idx.
  - Comparisons are strict, so ties keep the earliest index.
  - mode changes mid-frame affect the pair path only, never the tracker.
- Index saturation: if the incremented idx would exceed 2^IDX_W-1, idx holds at the all-ones value and idx_ovf is set. idx_ovf is sticky until the next in_first.
- in_valid & in_last with the frame active (same beat as in_first allowed, giving a single-beat frame):
  - The last beat is included in the tracking.
  - frame_done=1 on the following cycle only, with final max/min/idx/idx_ovf present on that same cycle.
  - frame_active is cleared.
- Result hold: max_val, min_val, max_idx, min_idx and idx_ovf hold after frame_done until the next in_first.
- Beats outside a frame: valid beats with no frame active (no in_first seen) produce pair flags only. in_last there produces no frame_done.
- Tracker states: IDLE (frame_active=0) and ACTIVE. Transitions:
  - IDLE→ACTIVE on first.
  - ACTIVE→IDLE on last.
  - ACTIVE→ACTIVE on first (restart).
  - first&last in IDLE: IDLE with frame_done pulse.
- Mid-frame reset discards the frame, with no frame_done.

Test Plan:
- WIDTH=8. a=80,b=7F: mode 00 → next cycle out_valid=1, flag=010. Same operands with mode 01 → flag=100. Reserved mode 11 → 010.
- Sign-magnitude, mode 10:
  - a=80,b=00 → flag=001.
  - a=85,b=83 → 100.
  - a=03,b=81 → 010.
- Frame, mode 01: beats a=03,FE,07,07,F8, with first on beat0 and last on beat4 → cycle after beat4 frame_done=1 for exactly 1 cycle, max_val=07, max_idx=2, min_val=F8, min_idx=4, idx_ovf=0; values held afterwards.
- Single-beat frame, first&last with a=42 → next cycle frame_done=1, max_val=min_val=42, both idx=0.
- Restart:
  - Sequence: first a=10, then a=20, then first a=05, then last a=01 → only one frame_done, with max_val=05 idx0, min_val=01 idx1.
  - IDX_W=2 with 6-beat frame → idx_ovf=1 and idx values ≤3.
- Reset and out-of-frame behaviour:
  - Assert rst between clock edges mid-frame → all outputs 0 immediately.
  - After release, in_last without in_first → no frame_done; pair flags still produced.
